width_gearbox: RTL

Parametrised bit-stream width converter that repacks IN_W-bit input words into OUT_W-bit output words, LSB first, with no bit loss for any IN_W/OUT_W ratio. It replaces fixed-ratio converters at the boundary between the link front end and downstream datapath. It adds valid/ready back-pressure on both sides and an optional flush that emits a trailing partial word.

---
 rtl/width_gearbox.sv | 87 ++++++++
 1 files changed

// File: rtl/width_gearbox.sv
// rtl/width_gearbox.sv - LSB-first IN_W to OUT_W bit-stream repacker with valid/ready on both sides
// Trailing partial-word flush is built only when GEARBOX_FLUSH_EN is defined.
module width_gearbox #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
`ifdef GEARBOX_FLUSH_EN
   ,
   input  logic             flush
`endif
);
   localparam int ACC_W = IN_W + OUT_W;
   localparam int CNT_W = $clog2(ACC_W + 1);
   localparam logic [CNT_W-1:0] IN_CNT  = CNT_W'(IN_W);
   localparam logic [CNT_W-1:0] OUT_CNT = CNT_W'(OUT_W);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_base;
   logic [CNT_W-1:0] cnt_nxt;
   logic             run;
   logic             drain;
   logic             push;
   logic             pop;

`ifdef GEARBOX_FLUSH_EN
   logic flush_pend;

   // A flush request wins over the clear so back-to-back requests stay pending.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flush_pend <= 1'b0;
      end else if (flush) begin
         flush_pend <= 1'b1;
      end else if (flush_pend && (cnt_nxt == '0)) begin
         flush_pend <= 1'b0;
      end
   end

   assign drain = flush_pend;
`else
   assign drain = 1'b0;
`endif

   // run keeps in_ready low until the first edge after reset release.
   assign in_ready  = run && (cnt <= OUT_CNT) && !drain;
   assign out_valid = (cnt >= OUT_CNT) || (drain && (cnt != '0));
   assign out_data  = acc[OUT_W-1:0];
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // The pop shift happens first so a same-cycle push lands above the survivors.
   always_comb begin
      acc_nxt  = acc;
      cnt_base = cnt;
      if (pop) begin
         acc_nxt  = acc >> OUT_W;
         cnt_base = (cnt >= OUT_CNT) ? (cnt - OUT_CNT) : '0;
      end
      cnt_nxt = cnt_base;
      if (push) begin
         acc_nxt = acc_nxt | (ACC_W'(in_data) << cnt_base);
         cnt_nxt = cnt_base + IN_CNT;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else begin
         acc <= acc_nxt;
         cnt <= cnt_nxt;
         run <= 1'b1;
      end
   end
endmodule
